serial_to_parallel8: RTL
========================

SERIAL_TO_PARALLEL8 -- requirements
Module: serial_to_parallel8

Interface
REQ-001 Parameter: LSB_FIRST, default 1, 1 = first accepted bit lands in dout[0]; 0 = first accepted bit lands in dout[7].
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 din  input  1  serial data bit.
REQ-005 din_valid  input  1  din is sampled on a clk edge when din_valid=1.
REQ-006 abort  input  1  discard the partial word and return to bit index 0.
REQ-007 dout  output  8  assembled word, stable while dout_valid=1.
REQ-008 dout_valid  output  1  dout holds an unconsumed word.
REQ-009 dout_ready  input  1  consumer accepts dout when dout_valid=1 and dout_ready=1.
REQ-010 bit_idx  output  3  index of the next bit to be written, 0..7.
REQ-011 overflow  output  1  sticky; a word completed while the output buffer was full.
REQ-012 parity_err  output  1  parity result for the word in dout (see REQ-030).

Function
REQ-013 The write position SHALL be LSB_FIRST ? bit_idx : 7-bit_idx; only that bit of the shift/collect register SHALL update on an accepted bit.
REQ-014 bit_idx SHALL increment by 1 per accepted bit and wrap from 7 to 0; the 8th accepted bit SHALL complete the word.
REQ-015 States: COLLECT (bits 0..7) and PARITY (compiled only with REQ-029); there is no IDLE state, and COLLECT with bit_idx=0 is the idle condition.
REQ-016 On word completion, the word SHALL transfer to dout and dout_valid SHALL go high on the next cycle (1-cycle latency from the last accepted bit).
REQ-017 dout_valid SHALL stay high, with dout unchanged, until a cycle with dout_ready=1.
REQ-018 If the word completes in the same cycle that dout is consumed, the new word SHALL load and dout_valid SHALL remain 1 with no bubble.
REQ-019 If the word completes while dout_valid=1 and dout_ready=0, the new word SHALL be dropped, dout SHALL be kept, and overflow SHALL set.
REQ-020 Collection SHALL never stall; din_valid has no back-pressure.
REQ-021 When abort=1, bit_idx SHALL go to 0 and the state to COLLECT next cycle, and any din accepted in that cycle SHALL be ignored; dout, dout_valid and overflow SHALL be unaffected.
REQ-022 abort and word completion in the same cycle: abort wins, and no word SHALL be produced.
REQ-023 overflow SHALL clear only on rst.

Reset
REQ-024 On rst=1 at a clk edge: dout=8'h00, dout_valid=0, bit_idx=0, overflow=0, parity_err=0, state=COLLECT, and the collect register SHALL be 0.
REQ-025 Reset SHALL take priority over all inputs, including mid-word; a partial word SHALL be discarded.
REQ-026 No output SHALL depend on an asynchronous path from rst.

Configuration
REQ-027 The macro SIPO8_PARITY_EN SHALL select parity checking.
REQ-028 Without the macro: 8 bits per word, and parity_err SHALL be tied to 0.
REQ-029 With the macro: after bit 7 the FSM SHALL enter PARITY; the 9th accepted bit is an even-parity bit and completes the word; bit_idx SHALL read 0 while in PARITY.
REQ-030 With the macro: parity_err SHALL load together with dout as XOR(word, parity bit), with 1 = error; a word with bad parity SHALL still be delivered.
REQ-031 With the macro, abort in PARITY SHALL return to COLLECT with no word produced.

Structure
REQ-032 Package sipo8_pkg SHALL hold WORD_W=8, IDX_W=3 and the state enum (COLLECT, PARITY).
REQ-033 Sub-module demux1by8 SHALL be a combinational 1-to-8 decoder with inputs d, s2, s1, s0 and output y[7:0], producing the per-bit write strobes.
REQ-034 All storage SHALL reside in serial_to_parallel8; there are no latches.

Verification
REQ-035 Reset, LSB_FIRST=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles, dout_ready=1 -> dout=8'hA5, dout_valid pulses 1 cycle, 1 cycle after the 8th bit.
REQ-036 LSB_FIRST=0, same bit stream -> dout=8'hA5 reversed = 8'hA5, then stream 1,1,0,0,0,0,0,0 -> 8'hC0.
REQ-037 dout_ready=0, two full words 8'h3C then 8'hFF -> dout stays 8'h3C, overflow=1; raise dout_ready -> dout_valid drops, overflow stays 1.
REQ-038 Abort after 5 bits, then 8 bits of 8'h81 -> dout=8'h81, with no spurious word; abort coincident with the 8th bit -> no dout_valid.
REQ-039 rst asserted after 4 bits -> all outputs reset values next cycle; the following 8 bits form a clean word.
REQ-040 SIPO8_PARITY_EN: 8'h07 with parity bit 1 -> parity_err=0; 8'h07 with parity bit 0 -> parity_err=1, dout=8'h07.

Source files
------------

// File: rtl/sipo8_pkg.sv
// Shared constants, FSM state encoding and write-position helper for the
// serial-to-parallel converter.
package sipo8_pkg;

  localparam int WORD_W = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } state_e;

  // Physical bit of the collect register written by logical bit index idx.
  function automatic logic [IDX_W-1:0] write_pos(input logic               lsb_first,
                                                  input logic [IDX_W-1:0] idx);
    return lsb_first ? idx : IDX_W'(WORD_W - 1) - idx;
  endfunction

endpackage

// File: rtl/demux1by8.sv
// Combinational 1-to-8 decoder: routes d onto y[{s2,s1,s0}], all other
// outputs low. Used to generate per-bit write strobes.
module demux1by8 (
  input  logic       d,
  input  logic       s2,
  input  logic       s1,
  input  logic       s0,
  output logic [7:0] y
);

  // NOTE: assign a default to every always_comb output before any
  // conditional write, otherwise unassigned paths infer latches.
  always_comb begin
    y               = '0;
    y[{s2, s1, s0}] = d;
  end

endmodule

// File: rtl/serial_to_parallel8.sv
// Serial-to-parallel 8-bit converter with one-word output buffer, abort and
// sticky overflow. Define SIPO8_PARITY_EN to add a trailing even-parity bit.
module serial_to_parallel8
  import sipo8_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_valid,
  input  logic              abort,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [IDX_W-1:0]  bit_idx,
  output logic              overflow,
  output logic              parity_err
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_W-1:0]   collect_q, collect_d;
  logic [WORD_W-1:0]   strobe;
  logic [IDX_W-1:0]    pos;
  logic                accept_bit;
  logic                word_done;
  logic [WORD_W-1:0]   word_d;
  logic                load_word;
  logic                drop_word;

  // A data bit is only written while collecting; abort masks it entirely.
  assign accept_bit = din_valid && !abort && (state_q == COLLECT);
  assign pos        = write_pos(LSB_FIRST, idx_q);

  demux1by8 u_demux (
    .d  (accept_bit),
    .s2 (pos[2]),
    .s1 (pos[1]),
    .s0 (pos[0]),
    .y  (strobe)
  );

  always_comb begin
    collect_d = collect_q;
    for (int i = 0; i < WORD_W; i++) begin
      if (strobe[i]) collect_d[i] = din;
    end
    if (abort) collect_d = '0;
  end

`ifdef SIPO8_PARITY_EN
  logic perr_d;
  logic perr_q;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    word_done = 1'b0;
    word_d    = collect_d;
`ifdef SIPO8_PARITY_EN
    perr_d    = 1'b0;
`endif
    case (state_q)
      COLLECT: begin
        if (accept_bit) begin
          idx_d = idx_q + IDX_W'(1);
`ifdef SIPO8_PARITY_EN
          if (idx_q == IDX_W'(WORD_W - 1)) state_d = PARITY;
`else
          if (idx_q == IDX_W'(WORD_W - 1)) word_done = 1'b1;
`endif
        end
      end
`ifdef SIPO8_PARITY_EN
      PARITY: begin
        // bit_idx already wrapped to 0 when bit 7 was taken.
        if (din_valid && !abort) begin
          word_done = 1'b1;
          word_d    = collect_q;
          perr_d    = (^collect_q) ^ din;
          state_d   = COLLECT;
        end
      end
`endif
      default: state_d = COLLECT;
    endcase
    if (abort) begin
      state_d   = COLLECT;
      idx_d     = '0;
      word_done = 1'b0;
    end
  end

  // A full buffer only accepts a new word if it is drained in the same cycle.
  assign load_word = word_done && (!dout_valid || dout_ready);
  assign drop_word = word_done && dout_valid && !dout_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      idx_q      <= '0;
      collect_q  <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      collect_q <= collect_d;
      if (load_word) begin
        dout       <= word_d;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
      if (drop_word) overflow <= 1'b1;
    end
  end

`ifdef SIPO8_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else if (load_word) begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign bit_idx = idx_q;

endmodule
